// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one signed MAC shared across all taps,
// valid/ready streaming on both sides, shadow/active coefficient banks
// with atomic commit between samples.
module fir_filter_mac #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned SHIFT  = 15
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  input  logic                    coef_commit,
  output logic                    commit_pending
);

  localparam int unsigned PTR_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + PTR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    state, state_nx;
  logic [PTR_W-1:0]          wptr, newest, cnt, idx_c;
  logic signed [DATA_W-1:0]  x_mem    [TAPS];
  logic signed [COEF_W-1:0]  coef_sh  [TAPS];
  logic signed [COEF_W-1:0]  coef_act [TAPS];
  logic signed [ACC_W-1:0]   acc, acc_nx_c, shifted_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic [ACC_W-DATA_W:0]     top_c;
  logic [DATA_W-1:0]         sat_c;
  logic                      accept_c, last_c, handshake_c, copy_c, addr_ok_c;
  logic                      in_ready_nx, out_valid_nx, pending_nx;

  assign last_c      = (state == S_MAC) && (cnt == PTR_W'(TAPS - 1));
  assign handshake_c = (state == S_OUT) && out_valid && out_ready;
  assign addr_ok_c   = ({1'b0, coef_addr} < (PTR_W + 1)'(TAPS));

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = bypass ? S_OUT : S_MAC;
      S_MAC:   if (last_c) state_nx = S_OUT;
      S_OUT:   if (handshake_c) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control decode and next values of the registered outputs
  always_comb begin
    accept_c     = 1'b0;
    copy_c       = 1'b0;
    in_ready_nx  = 1'b1;
    out_valid_nx = 1'b0;
    pending_nx   = commit_pending;
    accept_c     = (state == S_IDLE) && in_valid;
    in_ready_nx  = (state_nx == S_IDLE);
    // out_valid rises one cycle after entering OUT, drops on the handshake
    out_valid_nx = (state == S_OUT) && !handshake_c;
    if (state == S_IDLE)         copy_c = coef_commit;
    else if (state_nx == S_IDLE) copy_c = coef_commit || commit_pending;
    if (copy_c)           pending_nx = 1'b0;
    else if (coef_commit) pending_nx = 1'b1;
  end

  // Tap select, multiply-accumulate and output saturation
  always_comb begin
    if (newest >= cnt) idx_c = newest - cnt;
    else               idx_c = PTR_W'({1'b0, newest} + (PTR_W + 1)'(TAPS) - {1'b0, cnt});
    prod_c    = PROD_W'(x_mem[idx_c]) * PROD_W'(coef_act[cnt]);
    acc_nx_c  = acc + ACC_W'(prod_c);
    shifted_c = acc_nx_c >>> SHIFT;
    top_c     = shifted_c[ACC_W-1:DATA_W-1];
    if (&top_c || !(|top_c)) sat_c = shifted_c[DATA_W-1:0];
    else if (shifted_c[ACC_W-1]) sat_c = {1'b1, {(DATA_W-1){1'b0}}};
    else                         sat_c = {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Handshake and commit status registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      in_ready       <= in_ready_nx;
      out_valid      <= out_valid_nx;
      commit_pending <= pending_nx;
    end
  end

  // Shadow writes and shadow-to-active commit (commit sees pre-write shadow)
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int k = 0; k < int'(TAPS); k++) begin
        coef_sh[k]  <= '0;
        coef_act[k] <= '0;
      end
    end else begin
      if (coef_we && addr_ok_c) coef_sh[coef_addr] <= coef_data;
      if (copy_c) begin
        for (int k = 0; k < int'(TAPS); k++) coef_act[k] <= coef_sh[k];
      end
    end
  end

  // Delay line, tap counter, accumulator and result register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int k = 0; k < int'(TAPS); k++) x_mem[k] <= '0;
      wptr     <= '0;
      newest   <= '0;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (accept_c) begin
        x_mem[wptr] <= in_data;
        newest      <= wptr;
        wptr        <= (wptr == PTR_W'(TAPS - 1)) ? '0 : wptr + PTR_W'(1);
        acc         <= '0;
        cnt         <= '0;
        if (bypass) out_data <= in_data;
      end
      if (state == S_MAC) begin
        acc <= acc_nx_c;
        cnt <= last_c ? '0 : cnt + PTR_W'(1);
        if (last_c) out_data <= sat_c;
      end
    end
  end

endmodule
